// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared encodings for the multi-cycle RV32I control unit
package rv_ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [2:0] {
    ALU_SUB = 3'b000, ALU_ADD = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011,
    ALU_SLL = 3'b100, ALU_SRL = 3'b101, ALU_SLT = 3'b110
  } alu_op_t;
  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10} imm_sel_t;
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7
  } state_t;
  typedef enum logic [1:0] {TC_NONE = 2'b00, TC_ILLEGAL = 2'b01, TC_IMEM = 2'b10, TC_DMEM = 2'b11} trap_cause_t;
  typedef enum logic [2:0] {CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH} instr_class_t;
  function automatic alu_op_t f3_alu(input logic [2:0] f3);
    case (f3)
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: single-cycle RV32I subset decode (legality, class, ALU/immediate controls)
module ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter bit ENABLE_BRANCH = 1'b1
) (
  input  logic [31:0]  instr,
  output logic         legal,
  output instr_class_t cls,
  output alu_op_t      alu_op,
  output logic         alu_src,
  output imm_sel_t     imm_sel
);
  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       f3_ok;
  logic       unused;
  assign op     = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign f3_ok  = f3 != 3'b011 && f3 != 3'b100;
  assign unused = ^{instr[24:15], instr[11:7]};
  always_comb begin
    legal   = 1'b0;
    cls     = CL_R;
    alu_op  = f3_alu(f3);
    alu_src = 1'b0;
    imm_sel = IMM_I;
    case (op)
      OP_R: begin
        legal  = f3_ok && (f7 == 7'b0 || (f7 == 7'b0100000 && f3 == 3'b000));
        alu_op = f7[5] ? ALU_SUB : f3_alu(f3);
      end
      OP_I: begin
        cls     = CL_I;
        alu_src = 1'b1;
        legal   = f3_ok && (f3 == 3'b001 || f3 == 3'b101 ? f7 == 7'b0 : 1'b1);
      end
      OP_LOAD: begin
        cls     = CL_LOAD;
        alu_src = 1'b1;
        alu_op  = ALU_ADD;
        legal   = f3 == 3'b010;
      end
      OP_STORE: begin
        cls     = CL_STORE;
        alu_src = 1'b1;
        alu_op  = ALU_ADD;
        imm_sel = IMM_S;
        legal   = f3 == 3'b010;
      end
      OP_BRANCH: begin
        cls     = CL_BRANCH;
        imm_sel = IMM_B;
        alu_op  = f3[2] ? ALU_SLT : ALU_SUB;
        legal   = ENABLE_BRANCH && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101);
      end
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with IR, stall timeout, sticky trap and retire count
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 15,
  parameter int RETIRE_W      = 32,
  parameter bit ENABLE_BRANCH = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                alu_zero,
  input  logic                alu_lt,
  output logic                imem_req,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCSrc,
  output logic                RegWrite,
  output logic                ALUSrc,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [2:0]          ALUOp,
  output logic [1:0]          ImmSel,
  output logic [31:0]         instr,
  output logic [2:0]          state,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] instret
);
  state_t       cur, nxt;
  logic [7:0]   wcnt;
  logic         timeout, legal, dec_src, taken, is_br;
  instr_class_t cls;
  alu_op_t      dec_op;
  imm_sel_t     dec_imm;
  ctrl_decode #(.ENABLE_BRANCH(ENABLE_BRANCH)) u_dec (
    .instr  (instr),
    .legal  (legal),
    .cls    (cls),
    .alu_op (dec_op),
    .alu_src(dec_src),
    .imm_sel(dec_imm)
  );
  assign state   = cur;
  assign trap    = cur == S_TRAP;
  assign timeout = wcnt == 8'(MEM_TIMEOUT);
  assign is_br   = cur == S_EXEC && cls == CL_BRANCH;
  // funct3 bit 0 inverts the sense (BNE/BGE), bit 2 picks the compare flag
  assign taken   = instr[12] ^ (instr[14] ? alu_lt : alu_zero);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cur <= S_FETCH;
    else cur <= nxt;
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  nxt = imem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE: nxt = legal ? S_EXEC : S_TRAP;
      S_EXEC:   nxt = cls == CL_BRANCH ? S_FETCH : (cls == CL_LOAD || cls == CL_STORE) ? S_MEM : S_WB;
      S_MEM:    nxt = dmem_ready ? (cls == CL_STORE ? S_FETCH : S_WB) : timeout ? S_TRAP : S_MEM;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_TRAP;
    endcase
  end
  always_comb begin
    imem_req = cur == S_FETCH;
    IRWrite  = imem_req && imem_ready;
    RegWrite = cur == S_WB;
    MemRead  = cur == S_MEM && cls == CL_LOAD;
    MemWrite = cur == S_MEM && cls == CL_STORE;
    PCWrite  = RegWrite || is_br || (MemWrite && dmem_ready);
    PCSrc    = is_br && taken;
    ALUOp    = cur == S_EXEC ? dec_op : ALU_SUB;
    ALUSrc   = cur == S_EXEC && dec_src;
    ImmSel   = cur == S_EXEC ? dec_imm : IMM_I;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr      <= 32'h00000013;
      wcnt       <= 8'd0;
      instret    <= '0;
      trap_cause <= TC_NONE;
    end else begin
      if (IRWrite) instr <= imem_rdata;
      wcnt <= (cur == nxt && (cur == S_FETCH || cur == S_MEM)) ? wcnt + 8'd1 : 8'd0;
      if (PCWrite) instret <= instret + RETIRE_W'(1);
      if (nxt == S_TRAP && cur != S_TRAP)
        trap_cause <= cur == S_FETCH ? TC_IMEM : cur == S_MEM ? TC_DMEM : TC_ILLEGAL;
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench; stimulus queues per-cycle expectations, monitor checks them
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0;
  logic        imem_req, IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc, MemRead, MemWrite, trap;
  logic [2:0]  ALUOp, state;
  logic [1:0]  ImmSel, trap_cause;
  logic [31:0] instr;
  logic [3:0]  instret;
  logic [12:0] ctl_vec;
  typedef struct {
    string      n;
    logic [2:0] st;
    logic [12:0] c;
    logic       tr;
    logic [1:0] tc;
    logic [3:0] cnt;
  } rec_t;
  rec_t q[$];
  int   checks = 0, errors = 0;
  logic [3:0] exp_cnt = 4'd0;
  multicycle_control #(.MEM_TIMEOUT(3), .RETIRE_W(4), .ENABLE_BRANCH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .alu_zero(alu_zero), .alu_lt(alu_lt), .imem_req(imem_req),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .ImmSel(ImmSel), .instr(instr),
    .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );
  assign ctl_vec = {imem_req, IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc, MemRead, MemWrite, ALUOp, ImmSel};
  always #5 clk = ~clk;
  function automatic logic [12:0] ctl(input bit req, irw, pcw, pcs, rw, as, mr, mw,
                                      input logic [2:0] op, input logic [1:0] imm);
    return {req, irw, pcw, pcs, rw, as, mr, mw, op, imm};
  endfunction
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      rec_t r;
      r = q.pop_front();
      checks++;
      if (state !== r.st || ctl_vec !== r.c || trap !== r.tr || trap_cause !== r.tc || instret !== r.cnt) begin
        errors++;
        $display("FAIL %s: got state=%0d ctl=%h trap=%b cause=%b instret=%0d, want state=%0d ctl=%h trap=%b cause=%b instret=%0d",
                 r.n, state, ctl_vec, trap, trap_cause, instret, r.st, r.c, r.tr, r.tc, r.cnt);
      end
    end
  end
  task automatic push(input string n, input logic [2:0] st, input logic [12:0] c,
                      input logic tr, input logic [1:0] tc, input logic [3:0] cnt);
    rec_t r;
    r.n = n; r.st = st; r.c = c; r.tr = tr; r.tc = tc; r.cnt = cnt;
    q.push_back(r);
  endtask
  task automatic exp(input string n, input logic [2:0] st, input logic [12:0] c,
                     input logic tr, input logic [1:0] tc);
    push(n, st, c, tr, tc, exp_cnt);
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    imem_ready = 0; dmem_ready = 0; alu_zero = 0; alu_lt = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    exp_cnt = 0;
  endtask
  task automatic reset_check(input string n);
    imem_ready = 0; dmem_ready = 0;
    push(n, 3'd0, ctl(1,0,0,0,0,0,0,0,3'b000,2'b00), 1'b0, 2'b00, 4'd0);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    exp_cnt = 0;
  endtask
  task automatic fetch_decode(input string n, input logic [31:0] code, input bit spur);
    imem_rdata = code; imem_ready = 1;
    exp({n, " fetch"}, 3'd0, ctl(1,1,0,0,0,0,0,0,3'b000,2'b00), 1'b0, 2'b00);
    imem_ready = spur; dmem_ready = spur;
    if (spur) imem_rdata = 32'h0000007F;
    exp({n, " decode"}, 3'd1, 13'd0, 1'b0, 2'b00);
  endtask
  task automatic alu_instr(input string n, input logic [31:0] code, input logic [2:0] op,
                           input bit as, input bit spur);
    fetch_decode(n, code, spur);
    exp({n, " exec"}, 3'd2, ctl(0,0,0,0,0,as,0,0,op,2'b00), 1'b0, 2'b00);
    exp({n, " wb"}, 3'd4, ctl(0,0,1,0,1,0,0,0,3'b000,2'b00), 1'b0, 2'b00);
    exp_cnt++;
    imem_ready = 0; dmem_ready = 0;
  endtask
  task automatic branch(input string n, input logic [31:0] code, input bit z, input bit l,
                        input logic [2:0] op, input bit tk);
    fetch_decode(n, code, 1'b0);
    alu_zero = z; alu_lt = l;
    exp({n, " exec"}, 3'd2, ctl(0,0,1,tk,0,0,0,0,op,2'b10), 1'b0, 2'b00);
    exp_cnt++;
    alu_zero = 0; alu_lt = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1);
  end
  initial begin
    do_reset();
    exp("reset idle", 3'd0, ctl(1,0,0,0,0,0,0,0,3'b000,2'b00), 1'b0, 2'b00);
    alu_instr("add", 32'h002081B3, 3'b001, 1'b0, 1'b0);
    fetch_decode("lw", 32'h0040A183, 1'b0);
    exp("lw exec", 3'd2, ctl(0,0,0,0,0,1,0,0,3'b001,2'b00), 1'b0, 2'b00);
    repeat (3) exp("lw stall", 3'd3, ctl(0,0,0,0,0,0,1,0,3'b000,2'b00), 1'b0, 2'b00);
    dmem_ready = 1;
    exp("lw mem done", 3'd3, ctl(0,0,0,0,0,0,1,0,3'b000,2'b00), 1'b0, 2'b00);
    dmem_ready = 0;
    exp("lw wb", 3'd4, ctl(0,0,1,0,1,0,0,0,3'b000,2'b00), 1'b0, 2'b00);
    exp_cnt++;
    fetch_decode("sw", 32'h0020A423, 1'b0);
    exp("sw exec", 3'd2, ctl(0,0,0,0,0,1,0,0,3'b001,2'b01), 1'b0, 2'b00);
    dmem_ready = 1;
    exp("sw mem", 3'd3, ctl(0,0,1,0,0,0,0,1,3'b000,2'b00), 1'b0, 2'b00);
    exp_cnt++;
    dmem_ready = 0;
    branch("beq taken", 32'h00208063, 1'b1, 1'b0, 3'b000, 1'b1);
    branch("bne not taken", 32'h00209063, 1'b1, 1'b0, 3'b000, 1'b0);
    branch("blt taken", 32'h0020C063, 1'b0, 1'b1, 3'b110, 1'b1);
    branch("bge not taken", 32'h0020D063, 1'b0, 1'b1, 3'b110, 1'b0);
    alu_instr("addi", 32'h00100093, 3'b001, 1'b1, 1'b0);
    alu_instr("ori spurious", 32'h0050E093, 3'b011, 1'b1, 1'b1);
    alu_instr("sub", 32'h402081B3, 3'b000, 1'b0, 1'b0);
    alu_instr("srli", 32'h0020D093, 3'b101, 1'b1, 1'b0);
    fetch_decode("sw abort", 32'h0020A423, 1'b0);
    exp("sw abort exec", 3'd2, ctl(0,0,0,0,0,1,0,0,3'b001,2'b01), 1'b0, 2'b00);
    exp("sw abort mem", 3'd3, ctl(0,0,0,0,0,0,0,1,3'b000,2'b00), 1'b0, 2'b00);
    reset_check("reset mid sw");
    fetch_decode("illegal", 32'h0000007F, 1'b0);
    imem_ready = 1; dmem_ready = 1;
    repeat (21) exp("trap hold", 3'd7, 13'd0, 1'b1, 2'b01);
    reset_check("trap cleared");
    repeat (4) exp("imem wait", 3'd0, ctl(1,0,0,0,0,0,0,0,3'b000,2'b00), 1'b0, 2'b00);
    exp("imem timeout", 3'd7, 13'd0, 1'b1, 2'b10);
    do_reset();
    checks++;
    if (instret !== 4'd0 || trap !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset after timeout: state=%0d trap=%b instret=%0d", state, trap, instret);
    end
    repeat (3) exp("imem late", 3'd0, ctl(1,0,0,0,0,0,0,0,3'b000,2'b00), 1'b0, 2'b00);
    alu_instr("addi on timeout cycle", 32'h00100093, 3'b001, 1'b1, 1'b0);
    fetch_decode("sw dmem", 32'h0020A423, 1'b0);
    exp("sw dmem exec", 3'd2, ctl(0,0,0,0,0,1,0,0,3'b001,2'b01), 1'b0, 2'b00);
    repeat (4) exp("dmem wait", 3'd3, ctl(0,0,0,0,0,0,0,1,3'b000,2'b00), 1'b0, 2'b00);
    exp("dmem timeout", 3'd7, 13'd0, 1'b1, 2'b11);
    do_reset();
    repeat (17) alu_instr("addi wrap", 32'h00100093, 3'b001, 1'b1, 1'b0);
    push("instret wrap", 3'd0, ctl(1,0,0,0,0,0,0,0,3'b000,2'b00), 1'b0, 2'b00, 4'd1);
    @(posedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (instret !== 4'd1 || state !== 3'd0 || imem_req !== 1'b1 || trap !== 1'b0) begin
      errors++;
      $display("FAIL wrap hold: state=%0d req=%b trap=%b instret=%0d", state, imem_req, trap, instret);
    end
    if (errors != 0) $display("FAIL %0d errors", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
